// File: rtl/branch_predictor_unit.sv
// Tagged direct-mapped BHT/BTB with saturating mispredict counter.
// Define BP_RAS_EN to add a return address stack (RAS_DEPTH entries).
module branch_predictor_unit #(
    parameter int DATA_W    = 64,
    parameter int ENTRIES   = 64,
    parameter int TAG_W     = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en,
    input  logic              clear,
    input  logic [DATA_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [DATA_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [DATA_W-1:0] upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [DATA_W-1:0] upd_target,
    input  logic              upd_is_call,
    input  logic              upd_is_ret,
    input  logic              upd_mispredict,
    output logic [31:0]       mispredict_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {
        T_BR  = 2'd0,
        T_JMP = 2'd1,
        T_RET = 2'd2
    } br_type_e;

    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("ENTRIES must be a power of 2 and >= 2");
    end
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras
        $error("RAS_DEPTH must be a power of 2 and >= 2");
    end

    logic [ENTRIES-1:0] vld_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    br_type_e           typ_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];
    logic [DATA_W-1:0]  tgt_q [ENTRIES];
    logic [31:0]        mis_cnt_q;

    logic [IDX_W-1:0]  lk_idx;
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [TAG_W-1:0]  up_tag;
    logic              lk_hit;
    logic              up_hit;
    logic              mark_ret;
    br_type_e          new_typ;
    logic              ras_nonempty;
    logic [DATA_W-1:0] ras_top;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    assign lk_hit = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = vld_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign pred_hit   = lk_hit;
    assign pred_taken = lk_hit && (typ_q[lk_idx] != T_BR || ctr_q[lk_idx][1]);

    // Lookup sees pre-update table and RAS contents; no bypass.
    always_comb begin
        pred_target = lookup_pc + DATA_W'(4);
        if (lk_hit && typ_q[lk_idx] == T_RET && ras_nonempty)
            pred_target = ras_top;
        else if (pred_taken)
            pred_target = tgt_q[lk_idx];
    end

    always_comb begin
        new_typ = upd_is_jump ? T_JMP : T_BR;
        if (mark_ret)
            new_typ = T_RET;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vld_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                typ_q[i] <= T_BR;
                ctr_q[i] <= 2'b01;
                tgt_q[i] <= '0;
            end
        end else if (en) begin
            if (clear) begin
                vld_q <= '0;
            end else if (upd_valid) begin
                if (up_hit) begin
                    if (typ_q[up_idx] == T_BR) begin
                        if (upd_taken) begin
                            if (ctr_q[up_idx] != 2'b11)
                                ctr_q[up_idx] <= ctr_q[up_idx] + 2'b01;
                            tgt_q[up_idx] <= upd_target;
                        end else if (ctr_q[up_idx] != 2'b00) begin
                            ctr_q[up_idx] <= ctr_q[up_idx] - 2'b01;
                        end
                    end else begin
                        tgt_q[up_idx] <= upd_target;
                        if (mark_ret)
                            typ_q[up_idx] <= T_RET;
                    end
                end else if (upd_taken || upd_is_jump) begin
                    vld_q[up_idx] <= 1'b1;
                    tag_q[up_idx] <= up_tag;
                    typ_q[up_idx] <= new_typ;
                    ctr_q[up_idx] <= 2'b10;
                    tgt_q[up_idx] <= upd_target;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            mis_cnt_q <= '0;
        else if (en && upd_valid && upd_mispredict && mis_cnt_q != 32'hFFFF_FFFF)
            mis_cnt_q <= mis_cnt_q + 32'd1;
    end

    assign mispredict_cnt = mis_cnt_q;

`ifdef BP_RAS_EN
    localparam int RAS_W = $clog2(RAS_DEPTH);

    logic [DATA_W-1:0] ras_q [RAS_DEPTH];
    logic [RAS_W-1:0]  ras_ptr_q;
    logic [RAS_W:0]    ras_cnt_q;
    logic [RAS_W-1:0]  ras_top_idx;
    logic [DATA_W-1:0] ret_addr;
    logic              push;
    logic              pop;

    assign mark_ret     = upd_is_ret;
    assign ras_top_idx  = ras_ptr_q - RAS_W'(1);
    assign ras_nonempty = (ras_cnt_q != '0);
    assign ras_top      = ras_q[ras_top_idx];
    assign ret_addr     = upd_pc + DATA_W'(4);
    assign push         = upd_valid && upd_is_call;
    assign pop          = upd_valid && upd_is_ret;

    // Circular buffer: a push when full overwrites the oldest slot.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++)
                ras_q[i] <= '0;
        end else if (en) begin
            if (clear) begin
                ras_ptr_q <= '0;
                ras_cnt_q <= '0;
            end else if (push && pop) begin
                ras_q[ras_top_idx] <= ret_addr;
            end else if (push) begin
                ras_q[ras_ptr_q] <= ret_addr;
                ras_ptr_q        <= ras_ptr_q + RAS_W'(1);
                if (ras_cnt_q != (RAS_W+1)'(RAS_DEPTH))
                    ras_cnt_q <= ras_cnt_q + (RAS_W+1)'(1);
            end else if (pop && ras_nonempty) begin
                ras_ptr_q <= ras_top_idx;
                ras_cnt_q <= ras_cnt_q - (RAS_W+1)'(1);
            end
        end
    end
`else
    logic unused_ras;

    assign mark_ret     = 1'b0;
    assign ras_nonempty = 1'b0;
    assign ras_top      = '0;
    assign unused_ras   = &{1'b0, upd_is_call, upd_is_ret, upd_pc};
`endif

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed-vector bench for branch_predictor_unit (default parameters).
module tb_branch_predictor_unit;
`ifdef BP_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        arst_n;
    logic        en;
    logic        clear;
    logic [63:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic        upd_is_call;
    logic        upd_is_ret;
    logic        upd_mispredict;
    logic [31:0] mispredict_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_predictor_unit dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .en             (en),
        .clear          (clear),
        .lookup_pc      (lookup_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_is_jump    (upd_is_jump),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_is_call    (upd_is_call),
        .upd_is_ret     (upd_is_ret),
        .upd_mispredict (upd_mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_upd();
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_is_jump    = 1'b0;
        upd_taken      = 1'b0;
        upd_target     = '0;
        upd_is_call    = 1'b0;
        upd_is_ret     = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic set_upd(input logic [63:0] pc, input logic jmp,
                           input logic tk, input logic [63:0] tgt,
                           input logic call, input logic ret,
                           input logic mis);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_is_jump    = jmp;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_is_call    = call;
        upd_is_ret     = ret;
        upd_mispredict = mis;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [63:0] pc);
        lookup_pc = pc;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] exp_t;
        arst_n    = 1'b0;
        en        = 1'b1;
        clear     = 1'b0;
        lookup_pc = '0;
        idle_upd();
        repeat (2) @(posedge clk);
        #3 arst_n = 1'b1;

        look(64'h100);
        chk("rst_hit", 64'(pred_hit), 64'h0);
        chk("rst_taken", 64'(pred_taken), 64'h0);
        chk("rst_tgt", pred_target, 64'h104);
        chk("rst_cnt", 64'(mispredict_cnt), 64'h0);

        set_upd(64'h100, 1'b0, 1'b1, 64'h80, 1'b0, 1'b0, 1'b1);
        look(64'h100);
        chk("alloc_same_cyc", 64'(pred_hit), 64'h0);
        tick();
        idle_upd();
        look(64'h100);
        chk("br_hit", 64'(pred_hit), 64'h1);
        chk("br_taken", 64'(pred_taken), 64'h1);
        chk("br_tgt", pred_target, 64'h80);
        chk("cnt_one", 64'(mispredict_cnt), 64'h1);

        repeat (3) begin
            set_upd(64'h100, 1'b0, 1'b0, 64'hDEAD, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle_upd();
        look(64'h100);
        chk("nt3_hit", 64'(pred_hit), 64'h1);
        chk("nt3_taken", 64'(pred_taken), 64'h0);
        chk("nt3_tgt", pred_target, 64'h104);

        set_upd(64'h200, 1'b1, 1'b1, 64'h400, 1'b0, 1'b0, 1'b0);
        tick();
        idle_upd();
        look(64'h100);
        chk("alias_old", 64'(pred_hit), 64'h0);
        look(64'h200);
        chk("alias_new", 64'(pred_hit), 64'h1);
        chk("jmp_taken", 64'(pred_taken), 64'h1);
        chk("jmp_tgt", pred_target, 64'h400);

        set_upd(64'h100, 1'b0, 1'b1, 64'h90, 1'b0, 1'b0, 1'b0);
        look(64'h100);
        chk("nobypass_hit", 64'(pred_hit), 64'h0);
        chk("nobypass_tgt", pred_target, 64'h104);
        tick();
        idle_upd();
        look(64'h100);
        chk("realloc_tgt", pred_target, 64'h90);

        repeat (2) begin
            set_upd(64'h100, 1'b0, 1'b1, 64'h90, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle_upd();
        look(64'h100);
        chk("sat_t2", 64'(pred_taken), 64'h1);
        repeat (3) begin
            set_upd(64'h100, 1'b0, 1'b1, 64'h90, 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_upd(64'h100, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        tick();
        idle_upd();
        look(64'h100);
        chk("sat_nt1", 64'(pred_taken), 64'h1);
        set_upd(64'h100, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        tick();
        idle_upd();
        look(64'h100);
        chk("sat_nt2", 64'(pred_taken), 64'h0);
        chk("sat_nt2_tgt", pred_target, 64'h104);

        en = 1'b0;
        set_upd(64'h600, 1'b1, 1'b1, 64'h700, 1'b0, 1'b0, 1'b1);
        tick();
        idle_upd();
        en = 1'b1;
        look(64'h600);
        chk("en_off_hit", 64'(pred_hit), 64'h0);
        chk("en_off_cnt", 64'(mispredict_cnt), 64'h1);

        set_upd(64'h104, 1'b1, 1'b1, 64'h140, 1'b0, 1'b0, 1'b0);
        tick();
        idle_upd();
        look(64'h104);
        chk("pre_clr_tgt", pred_target, 64'h140);

        clear = 1'b1;
        set_upd(64'h500, 1'b1, 1'b1, 64'h600, 1'b0, 1'b0, 1'b0);
        tick();
        clear = 1'b0;
        idle_upd();
        look(64'h100);
        chk("clr_0x100", 64'(pred_hit), 64'h0);
        look(64'h104);
        chk("clr_0x104", 64'(pred_hit), 64'h0);
        look(64'h500);
        chk("clr_noalloc", 64'(pred_hit), 64'h0);
        chk("clr_cnt", 64'(mispredict_cnt), 64'h1);

        force dut.mis_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.mis_cnt_q;
        set_upd(64'h500, 1'b1, 1'b1, 64'h600, 1'b0, 1'b0, 1'b1);
        tick();
        chk("cnt_max", 64'(mispredict_cnt), 64'hFFFF_FFFF);
        repeat (2) tick();
        idle_upd();
        chk("cnt_hold", 64'(mispredict_cnt), 64'hFFFF_FFFF);

        set_upd(64'h300, 1'b1, 1'b1, 64'h800, 1'b0, 1'b1, 1'b0);
        tick();
        idle_upd();
        look(64'h300);
        chk("ret_hit", 64'(pred_hit), 64'h1);
        chk("ret_tgt_empty", pred_target, 64'h800);

        for (int i = 1; i <= 5; i++) begin
            set_upd(64'h10 * 64'(i), 1'b1, 1'b1, 64'h1000, 1'b1, 1'b0, 1'b0);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            set_upd(64'h300, 1'b1, 1'b1, 64'h800, 1'b0, 1'b1, 1'b0);
            look(64'h300);
            exp_t = (RAS && k < 4) ? 64'h54 - 64'h10 * 64'(k) : 64'h800;
            chk($sformatf("ras_pop%0d", k), pred_target, exp_t);
            tick();
        end
        idle_upd();
        look(64'h300);
        chk("ras_extra_pop", pred_target, 64'h800);

        set_upd(64'h60, 1'b1, 1'b1, 64'h1000, 1'b1, 1'b0, 1'b0);
        tick();
        idle_upd();
        look(64'h300);
        chk("ras_push_after", pred_target, RAS ? 64'h64 : 64'h800);

        set_upd(64'h700, 1'b1, 1'b1, 64'h900, 1'b0, 1'b0, 1'b1);
        look(64'h700);
        #2 arst_n = 1'b0;
        tick();
        idle_upd();
        look(64'h700);
        chk("mrst_hit", 64'(pred_hit), 64'h0);
        chk("mrst_taken", 64'(pred_taken), 64'h0);
        chk("mrst_tgt", pred_target, 64'h704);
        chk("mrst_cnt", 64'(mispredict_cnt), 64'h0);
        #2 arst_n = 1'b1;
        look(64'h300);
        chk("mrst_0x300", 64'(pred_hit), 64'h0);
        look(64'h10);
        chk("mrst_0x10", 64'(pred_hit), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
